ddram_clear: RTL and testbench

Sequencer that fills a region of DDR3 with a constant (or pseudo-random) pattern through the 64-bit Avalon-MM burst write port. It replaces the free-running address/write-enable counter in the menu core: the core pulses `start` after PLL lock, and this block drives the DDRAM write master until the region is cleared. It reports `busy` and `done` so the core or HPS can gate core handover.

---
 rtl/ddram_clear.sv | 142 ++++++++++++++
 tb/tb_ddram_clear.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ddram_clear.sv
// rtl/ddram_clear.sv - DDR3 region fill sequencer driving the DDRAM Avalon-MM burst write port
// Optional pseudo-random fill pattern: define DDRAM_CLEAR_LFSR_EN.
module ddram_clear #(
  parameter logic [28:0] BASE_ADDR = 29'h0,
  parameter logic [28:0] WORDS     = 29'h0400_0000,
  parameter int unsigned BURST     = 128,
  parameter logic [63:0] FILL      = 64'h0,
  parameter logic [63:0] SEED      = 64'h1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [28:0] words_done,
  input  logic        DDRAM_BUSY,
  output logic        DDRAM_WE,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE
);

  typedef enum logic [1:0] {IDLE, ARM, BEAT, DONE} state_t;

  localparam logic [28:0] BURST_W = 29'(BURST);

  state_t      state, state_nxt;
  logic        start_q, abort_seen, done_q, we_q;
  logic [28:0] rem, wcnt, next_addr, addr_q;
  logic [7:0]  burstcnt_q, beat_cnt, burst_len;
  logic [63:0] din;
  logic        start_edge, accept, last_beat;

  assign start_edge = start && !start_q;
  assign accept     = we_q && !DDRAM_BUSY;
  assign last_beat  = accept && (beat_cnt == 8'd1);
  assign burst_len  = (rem < BURST_W) ? rem[7:0] : BURST_W[7:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_edge) state_nxt = ARM;
      ARM:        state_nxt = abort ? IDLE : BEAT;
      BEAT: begin
        if (last_beat) begin
          // rem still holds the pre-decrement value on the final beat
          if (rem == 29'd1)               state_nxt = DONE;
          else if (abort_seen || abort)   state_nxt = IDLE;
          else                            state_nxt = ARM;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state == ARM) || (state == BEAT);
    done           = done_q;
    words_done     = wcnt;
    DDRAM_WE       = we_q;
    DDRAM_ADDR     = addr_q;
    DDRAM_BURSTCNT = burstcnt_q;
    DDRAM_DIN      = din;
    DDRAM_BE       = 8'hFF;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      abort_seen <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      rem        <= 29'd0;
      wcnt       <= 29'd0;
      next_addr  <= 29'd0;
      addr_q     <= 29'd0;
      burstcnt_q <= 8'd0;
      beat_cnt   <= 8'd0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            wcnt      <= 29'd0;
            rem       <= WORDS;
            done_q    <= 1'b0;
            next_addr <= BASE_ADDR;
          end
        end
        ARM: begin
          if (!abort) begin
            addr_q     <= next_addr;
            burstcnt_q <= burst_len;
            beat_cnt   <= burst_len;
            we_q       <= 1'b1;
            abort_seen <= 1'b0;
          end
        end
        BEAT: begin
          if (abort) abort_seen <= 1'b1;
          if (accept) begin
            wcnt     <= wcnt + 29'd1;
            rem      <= rem - 29'd1;
            beat_cnt <= beat_cnt - 8'd1;
          end
          if (last_beat) begin
            we_q      <= 1'b0;
            next_addr <= next_addr + 29'(burstcnt_q);
            if (rem == 29'd1) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DDRAM_CLEAR_LFSR_EN
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  logic [63:0] lfsr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      lfsr <= SEED;
    else if ((state == IDLE || state == DONE) && start_edge)
      lfsr <= SEED;
    else if (accept)
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 64'h0);
  end

  assign din = lfsr;
`else
  assign din = FILL;
`endif

endmodule

// File: tb/tb_ddram_clear.sv
// tb/tb_ddram_clear.sv - directed bench for ddram_clear (WORDS=10, BURST=4, BASE=0x100)
// Also checks the LFSR pattern when built with DDRAM_CLEAR_LFSR_EN.
module tb_ddram_clear;

  localparam logic [28:0] BASE  = 29'h100;
  localparam logic [28:0] NW    = 29'd10;
  localparam int          NB    = 4;
  localparam logic [63:0] FILLV = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] SEEDV = 64'h1;
  localparam logic [63:0] MASK  = 64'hD800_0000_0000_0000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, DDRAM_BUSY = 1'b0;
  logic        busy, done, DDRAM_WE;
  logic [28:0] words_done, DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [63:0] DDRAM_DIN;

  int n_vec = 0;
  int n_miss = 0;
  int beats, gaps;

  always #5 clk_sys = ~clk_sys;

  ddram_clear #(
    .BASE_ADDR(BASE), .WORDS(NW), .BURST(NB), .FILL(FILLV), .SEED(SEEDV)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .words_done(words_done),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_WE(DDRAM_WE), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_wd"}, 64'(words_done), 64'd0);
    chk({tag, "_we"}, 64'(DDRAM_WE), 64'd0);
    chk({tag, "_addr"}, 64'(DDRAM_ADDR), 64'd0);
    chk({tag, "_bcnt"}, 64'(DDRAM_BURSTCNT), 64'd0);
`ifdef DDRAM_CLEAR_LFSR_EN
    chk({tag, "_din"}, DDRAM_DIN, SEEDV);
`else
    chk({tag, "_din"}, DDRAM_DIN, FILLV);
`endif
    chk({tag, "_be"}, 64'(DDRAM_BE), 64'hFF);
  endtask

  // One fill: stall DDRAM_BUSY for stall_len cycles on beat index stall_at,
  // pulse abort during beat abort_at, pulse start during beat restart_at.
  task automatic run_fill(input int stall_at, input int stall_len, input int abort_at,
                          input int restart_at, output int nb, output int ng);
    int          sc;
    logic        prev_acc;
    logic [63:0] exp_din;
    logic [28:0] left;
    logic [63:0] lfsr_ref [3];
    lfsr_ref[0] = 64'h1;
    lfsr_ref[1] = 64'hD800_0000_0000_0000;
    lfsr_ref[2] = 64'h6C00_0000_0000_0000;
    nb = 0; ng = 0; sc = 0; prev_acc = 1'b0;
`ifdef DDRAM_CLEAR_LFSR_EN
    exp_din = SEEDV;
`else
    exp_din = FILLV;
`endif
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
    @(negedge clk_sys);
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_we", 64'(DDRAM_WE), 64'd0);
    chk("arm_done", 64'(done), 64'd0);
    chk("arm_wd", 64'(words_done), 64'd0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_sys); #1;
      DDRAM_BUSY = (nb == stall_at) && (sc < stall_len);
      if (DDRAM_BUSY) sc++;
      abort = (nb == abort_at) && DDRAM_WE;
      start = (nb == restart_at) && DDRAM_WE;
      @(negedge clk_sys);
      if (!busy) break;
      if (DDRAM_WE) begin
        left = NW - 29'(nb / NB * NB);
        chk("beat_addr", 64'(DDRAM_ADDR), 64'(BASE + 29'(nb / NB * NB)));
        chk("beat_bcnt", 64'(DDRAM_BURSTCNT), (left < 29'(NB)) ? 64'(left) : 64'(NB));
        chk("beat_din", DDRAM_DIN, exp_din);
`ifdef DDRAM_CLEAR_LFSR_EN
        if (nb < 3) chk("lfsr_vec", DDRAM_DIN, lfsr_ref[nb]);
`endif
        if (!DDRAM_BUSY) begin
          chk("beat_wd", 64'(words_done), 64'(nb));
          nb++;
          prev_acc = 1'b1;
`ifdef DDRAM_CLEAR_LFSR_EN
          exp_din = (exp_din >> 1) ^ (exp_din[0] ? MASK : 64'h0);
`endif
        end else begin
          prev_acc = 1'b0;
        end
      end else begin
        ng++;
        prev_acc = 1'b0;
      end
      if (c == 199) chk("fill_timeout", 64'd1, 64'd0);
    end
    DDRAM_BUSY = 1'b0; abort = 1'b0; start = 1'b0;
    chk("busy_fall_after_beat", 64'(prev_acc), 64'd1);
  endtask

  initial begin
    #23;
    chk_reset_outputs("rst");
    @(posedge clk_sys); #1 reset_n = 1'b1;
    @(negedge clk_sys);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // short fill, no stall
    run_fill(-1, 0, -1, -1, beats, gaps);
    chk("fill_beats", 64'(beats), 64'd10);
    chk("fill_gaps", 64'(gaps), 64'd2);
    chk("fill_done", 64'(done), 64'd1);
    chk("fill_wd", 64'(words_done), 64'd10);
    chk("fill_we_low", 64'(DDRAM_WE), 64'd0);

    // five-cycle stall on beat 2; restart from DONE clears done
    run_fill(1, 5, -1, -1, beats, gaps);
    chk("stall_beats", 64'(beats), 64'd10);
    chk("stall_gaps", 64'(gaps), 64'd2);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_wd", 64'(words_done), 64'd10);

    // abort on first beat of second burst
    run_fill(-1, 0, 4, -1, beats, gaps);
    chk("abort_beats", 64'(beats), 64'd8);
    chk("abort_gaps", 64'(gaps), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_wd", 64'(words_done), 64'd8);
    repeat (6) begin
      @(negedge clk_sys);
      chk("abort_no_burst3", 64'({busy, DDRAM_WE}), 64'd0);
    end

    // start edge while busy is ignored
    run_fill(-1, 0, -1, 5, beats, gaps);
    chk("restart_beats", 64'(beats), 64'd10);
    chk("restart_gaps", 64'(gaps), 64'd2);
    chk("restart_done", 64'(done), 64'd1);
    chk("restart_wd", 64'(words_done), 64'd10);

    // abort in DONE has no effect
    @(posedge clk_sys); #1 abort = 1'b1;
    @(posedge clk_sys); #1 abort = 1'b0;
    @(negedge clk_sys);
    chk("done_abort_done", 64'(done), 64'd1);
    chk("done_abort_busy", 64'(busy), 64'd0);
    chk("done_abort_wd", 64'(words_done), 64'd10);

    // reset asserted at beat 3, away from any clock edge
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
    repeat (4) @(posedge clk_sys);
    #2;
    chk("pre_rst_wd", 64'(words_done), 64'd3);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk_sys); #1 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      chk("idle_after_rst", 64'({busy, DDRAM_WE, done}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
